alu_rmw_seq: RTL and testbench

Sequencer that drives the 8-bit ALU for read-modify-write memory instructions (ASL, LSR, ROL, ROR, INC, DEC). It accepts one request from the CPU control unit and reads the operand from memory. It writes the unmodified byte back (the 6502 dummy write), computes the result through the ALU's mode/operand/carry inputs, writes the result, and reports N/Z/C flag updates. It is the initiator side of the ALU port and sits between instruction decode and the memory bus.

---
 rtl/alu_rmw_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_rmw_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rmw_seq.sv
// rtl/alu_rmw_seq.sv - read-modify-write sequencer driving the 8-bit ALU for ASL/LSR/ROL/ROR/INC/DEC
//
// Purpose: accepts one RMW request, performs READ -> dummy WRITE (unmodified
// byte) -> result WRITE on the memory bus, programs the ALU for the operation
// and reports the new N/Z/C flags with a one-cycle done pulse.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/
//   req_addr/c_in                     request from the control unit
//   mem_addr/mem_rd/mem_wr/
//   mem_wdata/mem_rdata               memory bus (read data one cycle after mem_rd)
//   alu_a/alu_b/alu_mode/
//   alu_carry_in/alu_out/
//   alu_carry_out                     ALU port (this block is the initiator)
//   done_valid/done_err/flag_n/
//   flag_z/flag_c/flag_c_we           completion and flag update

package alu_rmw_seq_pkg;
  // Shared ALU mode encodings
  parameter logic [4:0] ALU_ADD = 5'h00;
  parameter logic [4:0] ALU_SR  = 5'h05;

  // RMW opcodes (6 and 7 are illegal)
  parameter logic [2:0] OP_ASL = 3'd0;
  parameter logic [2:0] OP_LSR = 3'd1;
  parameter logic [2:0] OP_ROL = 3'd2;
  parameter logic [2:0] OP_ROR = 3'd3;
  parameter logic [2:0] OP_INC = 3'd4;
  parameter logic [2:0] OP_DEC = 3'd5;
endpackage

module alu_rmw_seq
  import alu_rmw_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic        c_in,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_mode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry_out,
  output logic        done_valid,
  output logic        done_err,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_c_we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DUMMY = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [15:0] r_addr;
  logic        r_c;
  logic [7:0]  r_opnd;
  logic        r_done_valid;
  logic        r_done_err;
  logic        r_flag_n;
  logic        r_flag_z;
  logic        r_flag_c;
  logic        r_flag_c_we;

  logic        w_req_legal;
  logic        w_op_shift;
  logic        w_res_zero;

  assign w_req_legal = (req_op <= OP_DEC);
  // Opcodes 0..3 are the shifts/rotates that update carry.
  assign w_op_shift  = (r_op <= OP_ROR);
  // Zero is taken from the 8-bit result only; the ALU's own zero output
  // folds in the carry bit and would be wrong for ASL 0x80.
  assign w_res_zero  = (alu_out == 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_addr       <= 16'h0000;
      r_c          <= 1'b0;
      r_opnd       <= 8'h00;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      r_flag_n     <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_c     <= 1'b0;
      r_flag_c_we  <= 1'b0;
    end else begin
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_addr <= req_addr;
            r_c    <= c_in;
            if (w_req_legal) begin
              r_state <= S_READ;
            end else begin
              // Illegal opcode: report immediately, no bus cycles.
              r_done_valid <= 1'b1;
              r_done_err   <= 1'b1;
              r_flag_n     <= 1'b0;
              r_flag_z     <= 1'b0;
              r_flag_c     <= 1'b0;
              r_flag_c_we  <= 1'b0;
            end
          end
        end
        S_READ: begin
          r_state <= S_DUMMY;
        end
        S_DUMMY: begin
          r_opnd  <= mem_rdata;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_flag_n     <= alu_out[7];
          r_flag_z     <= w_res_zero;
          // INC/DEC leave carry untouched; the ALU carry-out is ignored.
          r_flag_c     <= w_op_shift ? alu_carry_out : 1'b0;
          r_flag_c_we  <= w_op_shift;
          r_done_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from registered state, so an asynchronous
  // reset drops the write strobe without waiting for a clock.
  assign req_ready = (r_state == S_IDLE);
  assign mem_rd    = (r_state == S_READ);
  assign mem_wr    = (r_state == S_DUMMY) || (r_state == S_WRITE);
  assign mem_addr  = (r_state == S_IDLE) ? 16'h0000 : r_addr;

  always_comb begin
    mem_wdata = 8'h00;
    case (r_state)
      S_DUMMY: mem_wdata = mem_rdata;
      S_WRITE: mem_wdata = alu_out;
      default: mem_wdata = 8'h00;
    endcase
  end

  // ALU programming: shifts left are opnd+opnd, shifts right use ALU_SR
  // with carry_in entering bit 7, INC adds carry, DEC adds 0xFF.
  always_comb begin
    alu_mode     = ALU_ADD;
    alu_a        = r_opnd;
    alu_b        = 8'h00;
    alu_carry_in = 1'b0;
    if (r_state == S_WRITE) begin
      case (r_op)
        OP_ASL: begin
          alu_b = r_opnd;
        end
        OP_ROL: begin
          alu_b        = r_opnd;
          alu_carry_in = r_c;
        end
        OP_LSR: begin
          alu_mode = ALU_SR;
        end
        OP_ROR: begin
          alu_mode     = ALU_SR;
          alu_carry_in = r_c;
        end
        OP_INC: begin
          alu_carry_in = 1'b1;
        end
        OP_DEC: begin
          alu_b = 8'hFF;
        end
        default: begin
          alu_mode = ALU_ADD;
        end
      endcase
    end
  end

  assign done_valid = r_done_valid;
  assign done_err   = r_done_err;
  assign flag_n     = r_flag_n;
  assign flag_z     = r_flag_z;
  assign flag_c     = r_flag_c;
  assign flag_c_we  = r_flag_c_we;

endmodule

// File: tb/tb_alu_rmw_seq.sv
// tb/tb_alu_rmw_seq.sv - directed self-checking bench for alu_rmw_seq

module tb_alu_rmw_seq;
  import alu_rmw_seq_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic        c_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_mode;
  logic        alu_carry_in;
  logic [7:0]  alu_out;
  logic        alu_carry_out;
  logic        done_valid;
  logic        done_err;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_c_we;

  logic [7:0]  mem_byte;
  int          n_asserts;
  int          n_fail;

  alu_rmw_seq dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .c_in          (c_in),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_mode      (alu_mode),
    .alu_carry_in  (alu_carry_in),
    .alu_out       (alu_out),
    .alu_carry_out (alu_carry_out),
    .done_valid    (done_valid),
    .done_err      (done_err),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .flag_c_we     (flag_c_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: returns the test operand the cycle after a read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_byte;
  end

  // ALU: ADD is a+b+cin with carry out; SR shifts right with cin into bit 7.
  always_comb begin
    alu_out       = 8'h00;
    alu_carry_out = 1'b0;
    if (alu_mode == ALU_ADD) begin
      {alu_carry_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
    end else if (alu_mode == ALU_SR) begin
      alu_out       = {alu_carry_in, alu_a[7:1]};
      alu_carry_out = alu_a[0];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the FSM idle; returns at T+4.
  task automatic do_rmw(input string nm, input logic [2:0] op, input logic [15:0] addr,
                        input logic cin, input logic [7:0] mval, input logic [7:0] res,
                        input logic en, input logic ez, input logic ec, input logic ecwe);
    chk({nm, ".ready_T"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    c_in      = cin;
    mem_byte  = mval;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, ".rd_T1"},    mem_rd,   1'b1);
    chk({nm, ".wr_T1"},    mem_wr,   1'b0);
    chk({nm, ".addr_T1"},  mem_addr, addr);
    chk({nm, ".ready_T1"}, req_ready, 1'b0);
    @(posedge clk); #1;
    chk({nm, ".rd_T2"},    mem_rd,    1'b0);
    chk({nm, ".wr_T2"},    mem_wr,    1'b1);
    chk({nm, ".wdata_T2"}, mem_wdata, mval);
    chk({nm, ".addr_T2"},  mem_addr,  addr);
    chk({nm, ".done_T2"},  done_valid, 1'b0);
    @(posedge clk); #1;
    chk({nm, ".wr_T3"},    mem_wr,    1'b1);
    chk({nm, ".wdata_T3"}, mem_wdata, res);
    chk({nm, ".addr_T3"},  mem_addr,  addr);
    @(posedge clk); #1;
    chk({nm, ".done_T4"},  done_valid, 1'b1);
    chk({nm, ".err_T4"},   done_err,   1'b0);
    chk({nm, ".n"},        flag_n,     en);
    chk({nm, ".z"},        flag_z,     ez);
    chk({nm, ".c"},        flag_c,     ec);
    chk({nm, ".cwe"},      flag_c_we,  ecwe);
    chk({nm, ".wr_T4"},    mem_wr,     1'b0);
    chk({nm, ".ready_T4"}, req_ready,  1'b1);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 16'h0000;
    c_in      = 1'b0;
    mem_byte  = 8'h00;

    #2;
    chk("rst.ready",  req_ready,    1'b1);
    chk("rst.rd",     mem_rd,       1'b0);
    chk("rst.wr",     mem_wr,       1'b0);
    chk("rst.addr",   mem_addr,     16'h0000);
    chk("rst.wdata",  mem_wdata,    8'h00);
    chk("rst.done",   done_valid,   1'b0);
    chk("rst.err",    done_err,     1'b0);
    chk("rst.flags",  {flag_n, flag_z, flag_c, flag_c_we}, 4'h0);
    chk("rst.mode",   alu_mode,     ALU_ADD);
    chk("rst.alu_a",  alu_a,        8'h00);
    chk("rst.alu_b",  alu_b,        8'h00);
    chk("rst.alu_ci", alu_carry_in, 1'b0);

    @(posedge clk); #1;
    reset_n = 1'b1;

    do_rmw("asl", OP_ASL, 16'h0200, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    do_rmw("ror", OP_ROR, 16'h0010, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    do_rmw("dec", OP_DEC, 16'h1234, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_rmw("inc", OP_INC, 16'h1234, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: second request accepted at T+4, done at T+8
    do_rmw("rol", OP_ROL, 16'h00F0, 1'b1, 8'h40, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    do_rmw("lsr", OP_LSR, 16'h00F1, 1'b0, 8'h03, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);

    // Illegal opcode
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_addr  = 16'h4000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ill.done",  done_valid, 1'b1);
    chk("ill.err",   done_err,   1'b1);
    chk("ill.rd",    mem_rd,     1'b0);
    chk("ill.wr",    mem_wr,     1'b0);
    chk("ill.cwe",   flag_c_we,  1'b0);
    chk("ill.ready", req_ready,  1'b1);
    do_rmw("post_ill", OP_ASL, 16'h4001, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the dummy write
    req_valid = 1'b1;
    req_op    = OP_INC;
    req_addr  = 16'h0300;
    mem_byte  = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid.rd", mem_rd, 1'b1);
    @(posedge clk); #1;
    chk("rst_mid.dummy_wr", mem_wr, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid.wr_drop", mem_wr,     1'b0);
    chk("rst_mid.addr",    mem_addr,   16'h0000);
    chk("rst_mid.wdata",   mem_wdata,  8'h00);
    chk("rst_mid.ready",   req_ready,  1'b1);
    chk("rst_mid.done",    done_valid, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid.done_hold", done_valid, 1'b0);
    reset_n = 1'b1;
    chk("rst_mid.done_rel", done_valid, 1'b0);
    do_rmw("post_rst_inc", OP_INC, 16'h01FF, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("end.done_clear", done_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
